// File: rtl/ex6_observer.sv
// rtl/ex6_observer.sv - ex6 controller output-word state tracker (optional OBSERVER_RESYNC_EN)
module ex6_observer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       y,
    input  logic             x3,
    output logic [3:0]       state,
    output logic             out_valid,
    output logic             err,
    output logic             err_sticky,
    output logic             halted,
    output logic [CNT_W-1:0] count
);

    // Codes with a single destination: legal_from bit i set means legal from state si.
    logic [15:0] legal_from;
    logic [3:0]  fixed_dest;
    logic        known_fixed;

    // Context-dependent codes (0x14, 0x21): destination depends on current state.
    logic [3:0]  ctx_dest;
    logic        ctx_legal;

    logic        legal;
    logic [3:0]  dest;

    // Decode single-destination codes into destination and legal-source mask.
    always_comb begin
        known_fixed = 1'b1;
        fixed_dest  = 4'd1;
        legal_from  = 16'h0000;
        case (y)
            8'h00: begin fixed_dest = 4'd1; legal_from = 16'h0002; end
            8'h1D: begin fixed_dest = 4'd2; legal_from = 16'h055E; end
            8'h03: begin fixed_dest = 4'd4; legal_from = 16'h04DA; end
            8'h0B: begin fixed_dest = 4'd5; legal_from = 16'h0004; end
            8'hAC: begin fixed_dest = 4'd3; legal_from = 16'h0004; end
            8'h1C: begin fixed_dest = 4'd4; legal_from = 16'h0004; end
            8'hA4: begin fixed_dest = 4'd5; legal_from = 16'h0068; end
            8'h70: begin fixed_dest = 4'd7; legal_from = 16'h0090; end
            8'h83: begin fixed_dest = 4'd4; legal_from = 16'h0020; end
            8'h9D: begin fixed_dest = 4'd8; legal_from = 16'h0020; end
            8'h94: begin fixed_dest = 4'd9; legal_from = 16'h0020; end
            default: known_fixed = 1'b0;
        endcase
    end

    // Resolve 0x14 and 0x21 against the tracked state; x3 only matters for 0x14 from s3.
    always_comb begin
        ctx_legal = 1'b0;
        ctx_dest  = state;
        case (y)
            8'h14: begin
                case (state)
                    4'd1, 4'd4, 4'd9: begin ctx_legal = 1'b1; ctx_dest = 4'd3; end
                    4'd6, 4'd10:      begin ctx_legal = 1'b1; ctx_dest = 4'd6; end
                    4'd3:             begin ctx_legal = 1'b1; ctx_dest = x3 ? 4'd6 : 4'd3; end
                    default:          ctx_legal = 1'b0;
                endcase
            end
            8'h21: begin
                case (state)
                    4'd7:    begin ctx_legal = 1'b1; ctx_dest = 4'd10; end
                    4'd10:   begin ctx_legal = 1'b1; ctx_dest = 4'd1;  end
                    default: ctx_legal = 1'b0;
                endcase
            end
            default: ctx_legal = 1'b0;
        endcase
    end

    // Combine both decoders into one accept/reject verdict.
    always_comb begin
        legal = known_fixed ? legal_from[state] : ctx_legal;
        dest  = known_fixed ? fixed_dest : ctx_dest;
    end

    // Track state, pulse accept/reject, count accepted words and latch errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= 4'd1;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            halted     <= 1'b0;
            count      <= '0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (in_valid && !halted) begin
                if (legal) begin
                    state     <= dest;
                    out_valid <= 1'b1;
                    if (count != {CNT_W{1'b1}}) begin
                        count <= count + 1'b1;
                    end
                end else begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
`ifdef OBSERVER_RESYNC_EN
                    // Unambiguous codes tell us where the controller now is.
                    if (known_fixed) begin
                        state <= fixed_dest;
                    end
`else
                    halted <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ex6_observer.sv
// tb/tb_ex6_observer.sv - self-checking bench for ex6_observer (honours OBSERVER_RESYNC_EN)
module tb_ex6_observer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] y = 8'h00;
    logic       x3 = 1'b0;

    logic [3:0]  st_a, st_b;
    logic        ov_a, ov_b, er_a, er_b, sk_a, sk_b, hl_a, hl_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    ex6_observer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y(y), .x3(x3),
        .state(st_a), .out_valid(ov_a), .err(er_a), .err_sticky(sk_a),
        .halted(hl_a), .count(cnt_a)
    );

    ex6_observer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .y(y), .x3(x3),
        .state(st_b), .out_valid(ov_b), .err(er_b), .err_sticky(sk_b),
        .halted(hl_b), .count(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Destination of word w from state s, or 0 when the controller could not emit it.
    function automatic int model_dest(input int s, input logic [7:0] w, input bit xx);
        case (w)
            8'h00: return (s == 1) ? 1 : 0;
            8'h1D: return (s inside {1, 2, 3, 4, 6, 8, 10}) ? 2 : 0;
            8'h03: return (s inside {1, 3, 4, 6, 7, 10}) ? 4 : 0;
            8'h0B: return (s == 2) ? 5 : 0;
            8'hAC: return (s == 2) ? 3 : 0;
            8'h1C: return (s == 2) ? 4 : 0;
            8'hA4: return (s inside {3, 5, 6}) ? 5 : 0;
            8'h70: return (s inside {4, 7}) ? 7 : 0;
            8'h83: return (s == 5) ? 4 : 0;
            8'h9D: return (s == 5) ? 8 : 0;
            8'h94: return (s == 5) ? 9 : 0;
            8'h14: begin
                if (s inside {1, 4, 9}) return 3;
                if (s inside {6, 10}) return 6;
                if (s == 3) return xx ? 6 : 3;
                return 0;
            end
            8'h21: begin
                if (s == 7) return 10;
                if (s == 10) return 1;
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    // Where an illegal but unambiguous word tells us the controller went (0 if unknown/ambiguous).
    function automatic int single_dest(input logic [7:0] w);
        case (w)
            8'h00: return 1;
            8'h1D: return 2;
            8'h03, 8'h1C, 8'h83: return 4;
            8'h0B, 8'hA4: return 5;
            8'hAC: return 3;
            8'h70: return 7;
            8'h9D: return 8;
            8'h94: return 9;
            default: return 0;
        endcase
    endfunction

    int m_state = 1;
    int m_cnt   = 0;
    bit m_ov = 0, m_err = 0, m_sticky = 0, m_halt = 0;

    // Reference model of the tracker.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 1; m_cnt = 0; m_ov = 0; m_err = 0; m_sticky = 0; m_halt = 0;
        end else begin
            m_ov = 0;
            m_err = 0;
            if (in_valid && !m_halt) begin
                int d;
                d = model_dest(m_state, y, x3);
                if (d != 0) begin
                    m_state = d;
                    m_ov = 1;
                    m_cnt++;
                end else begin
                    m_err = 1;
                    m_sticky = 1;
`ifdef OBSERVER_RESYNC_EN
                    if (single_dest(y) != 0) m_state = single_dest(y);
`else
                    m_halt = 1;
`endif
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",      st_a, m_state);
            chk("out_valid",  ov_a, m_ov);
            chk("err",        er_a, m_err);
            chk("err_sticky", sk_a, m_sticky);
            chk("halted",     hl_a, m_halt);
            chk("count16",    cnt_a, (m_cnt > 65535) ? 65535 : m_cnt);
            chk("state_w4",   st_b, m_state);
            chk("ov_w4",      ov_b, m_ov);
            chk("err_w4",     er_b, m_err);
            chk("halted_w4",  hl_b, m_halt);
            chk("count4",     cnt_b, (m_cnt > 15) ? 15 : m_cnt);
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic word(input logic [7:0] w, input bit xx);
        in_valid = 1'b1; y = w; x3 = xx;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [7:0] codes [13] = '{8'h00, 8'h1D, 8'h03, 8'h0B, 8'hAC, 8'h1C, 8'hA4,
                               8'h70, 8'h83, 8'h9D, 8'h94, 8'h14, 8'h21};

    task automatic rand_block(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] w;
            bit xx;
            xx = 1'($urandom_range(0, 1));
            w  = codes[$urandom_range(0, 12)];
            if ($urandom_range(0, 19) == 0) begin
                w = 8'($urandom_range(0, 255));
            end else begin
                for (int t = 0; t < 8 && model_dest(m_state, w, xx) == 0; t++)
                    w = codes[$urandom_range(0, 12)];
            end
            in_valid = ($urandom_range(0, 3) != 0);
            y = w; x3 = xx;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // Reset values
        do_reset();
        chk("rst_state", st_a, 1);
        chk("rst_count", cnt_a, 0);
        chk("rst_sticky", sk_a, 0);

        // 0x1D, 0xAC, 0x14(x3=1)
        do_reset();
        word(8'h1D, 0); chk("t1_s2", st_a, 2); chk("t1_ov", ov_a, 1);
        word(8'hAC, 0); chk("t1_s3", st_a, 3);
        word(8'h14, 1); chk("t1_s6", st_a, 6);
        chk("t1_cnt", cnt_a, 3); chk("t1_sticky", sk_a, 0);

        // 0x03, 0x70, 0x21, 0x21
        do_reset();
        word(8'h03, 0); chk("t2_s4", st_a, 4);
        word(8'h70, 0); chk("t2_s7", st_a, 7);
        word(8'h21, 0); chk("t2_s10", st_a, 10);
        word(8'h21, 0); chk("t2_s1", st_a, 1);
        chk("t2_cnt", cnt_a, 4);

        // 0x14 from s3 with x3=0 then x3=1
        do_reset();
        word(8'h1D, 0); word(8'hAC, 1);
        word(8'h14, 0); chk("t3_hold3", st_a, 3);
        word(8'h14, 1); chk("t3_to6", st_a, 6);

        // Illegal 0x0B from s1
        do_reset();
        word(8'h0B, 0); chk("t4_err", er_a, 1); chk("t4_sticky", sk_a, 1);
`ifdef OBSERVER_RESYNC_EN
        chk("t4_resync", st_a, 5); chk("t4_halt", hl_a, 0);
        word(8'hA4, 0); chk("t4_acc", ov_a, 1); chk("t4_s5", st_a, 5); chk("t4_cnt", cnt_a, 1);
`else
        chk("t4_s1", st_a, 1); chk("t4_halt", hl_a, 1);
        word(8'h1D, 0); chk("t4_ign", ov_a, 0); chk("t4_s1b", st_a, 1); chk("t4_cnt", cnt_a, 0);
`endif

        // Unknown 0xFF, then mid-stream reset with a word at the reset edge
        do_reset();
        word(8'hFF, 0); chk("t5_err", er_a, 1); chk("t5_s1", st_a, 1);
        in_valid = 1'b1; y = 8'h1D; x3 = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_async_sticky", sk_a, 0);
        chk("t5_async_halt", hl_a, 0);
        @(posedge clk); #1;
        chk("t5_rst_state", st_a, 1); chk("t5_rst_cnt", cnt_a, 0); chk("t5_rst_ov", ov_a, 0);
        rst = 1'b1;
        word(8'h1D, 0); chk("t5_after", st_a, 2); chk("t5_after_ov", ov_a, 1);

        // Saturation on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            word(8'h00, 0);
            chk("t6_ov", ov_b, 1);
        end
        chk("t6_cnt4", cnt_b, 15); chk("t6_cnt16", cnt_a, 20); chk("t6_state", st_b, 1);

        // Randomized traffic against the model
        for (int b = 0; b < 30; b++) begin
            do_reset();
            rand_block(60);
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
